// File: rtl/fifo_mavg_reader.sv
// Moving-average consumer on the read side of an async FIFO: pops show-ahead samples,
// keeps a 2^WIN_LOG2 sliding window with a running sum, and emits the average over
// valid/ready. Define MAVG_ROUND_EN for round-half-up averaging instead of truncation.
module fifo_mavg_reader #(
   parameter int D_WIDTH  = 8,
   parameter int WIN_LOG2 = 2
) (
   input  logic               r_clk,
   input  logic               r_rstn,
   input  logic               clr,
   input  logic               empty,
   input  logic [D_WIDTH-1:0] r_data,
   output logic               r_inc,
   output logic [D_WIDTH-1:0] out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               win_full
);

   localparam int N       = 1 << WIN_LOG2;
   localparam int S_WIDTH = D_WIDTH + WIN_LOG2;

`ifdef MAVG_ROUND_EN
   localparam logic [S_WIDTH-1:0] RND = S_WIDTH'(N / 2);
`else
   localparam logic [S_WIDTH-1:0] RND = '0;
`endif

   typedef enum logic {FILL, RUN} state_t;

   state_t              state_q, state_d;
   logic [WIN_LOG2-1:0] cnt_q, cnt_d;
   logic [WIN_LOG2-1:0] idx_q, idx_d;
   logic [D_WIDTH-1:0]  win_q [N];
   logic [D_WIDTH-1:0]  win_d [N];
   logic [S_WIDTH-1:0]  sum_q, sum_d, sum_nxt;
   logic [D_WIDTH-1:0]  out_data_q, out_data_d;
   logic                out_valid_q, out_valid_d;
   logic                can_take, pop, produce;

   // Gating with r_rstn keeps the FIFO from losing a sample while we are held in reset.
   assign can_take = !out_valid_q || out_ready;
   assign pop      = r_rstn && !empty && can_take && !clr;
   assign r_inc    = pop;

   // The oldest sample is always part of the sum, so the subtraction never underflows.
   assign sum_nxt  = sum_q + S_WIDTH'(r_data) - S_WIDTH'(win_q[idx_q]);
   assign produce  = pop && (state_q == RUN || cnt_q == WIN_LOG2'(N - 1));

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      win_d       = win_q;
      sum_d       = sum_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;

      if (clr) begin
         state_d     = FILL;
         cnt_d       = '0;
         idx_d       = '0;
         sum_d       = '0;
         out_data_d  = '0;
         out_valid_d = 1'b0;
         for (int i = 0; i < N; i++) win_d[i] = '0;
      end else begin
         if (pop) begin
            win_d[idx_q] = r_data;
            idx_d        = idx_q + 1'b1;
            sum_d        = sum_nxt;
            if (state_q == FILL) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == WIN_LOG2'(N - 1)) state_d = RUN;
            end
         end
         if (produce) begin
            out_valid_d = 1'b1;
            out_data_d  = D_WIDTH'((sum_nxt + RND) >> WIN_LOG2);
         end else if (out_ready) begin
            out_valid_d = 1'b0;
         end
      end
   end

   // NOTE: the window buffer is reset because FILL relies on evicting zeros from it.
   always_ff @(posedge r_clk or negedge r_rstn) begin
      if (!r_rstn) begin
         state_q     <= FILL;
         cnt_q       <= '0;
         idx_q       <= '0;
         sum_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         for (int i = 0; i < N; i++) win_q[i] <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only.
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         sum_q       <= sum_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         for (int i = 0; i < N; i++) win_q[i] <= win_d[i];
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign win_full  = (state_q == RUN);

endmodule

// File: tb/tb_fifo_mavg_reader.sv
// Directed self-checking bench for fifo_mavg_reader (D_WIDTH=8, WIN_LOG2=2);
// expected averages are hand-computed, with the rounding build selected by MAVG_ROUND_EN.
module tb_fifo_mavg_reader;

   logic       r_clk = 1'b0;
   logic       r_rstn;
   logic       clr;
   logic       empty;
   logic [7:0] r_data;
   logic       r_inc;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       win_full;

   int checks   = 0;
   int failures = 0;

   fifo_mavg_reader #(.D_WIDTH(8), .WIN_LOG2(2)) dut (
      .r_clk     (r_clk),
      .r_rstn    (r_rstn),
      .clr       (clr),
      .empty     (empty),
      .r_data    (r_data),
      .r_inc     (r_inc),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .win_full  (win_full)
   );

   always #5 r_clk = ~r_clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge r_clk);
      #1;
   endtask

   // Present one sample on a non-empty FIFO, confirm the pop, and step past the edge.
   task automatic pop_one(input logic [7:0] d);
      empty  = 1'b0;
      r_data = d;
      #1;
      check("r_inc_pop", int'(r_inc), 1);
      tick();
      empty = 1'b1;
   endtask

   task automatic expect_out(input string tag, input int v, input int d, input int f);
      check({tag, "_valid"}, int'(out_valid), v);
      if (v == 1) check({tag, "_data"}, int'(out_data), d);
      check({tag, "_full"}, int'(win_full), f);
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      r_rstn = 1'b0; clr = 1'b0; empty = 1'b1; r_data = '0; out_ready = 1'b1;
      #1;
      // 1. Reset state and no pop while held in reset.
      check("rst_valid", int'(out_valid), 0);
      check("rst_data",  int'(out_data),  0);
      check("rst_full",  int'(win_full),  0);
      check("rst_rinc",  int'(r_inc),     0);
      empty = 1'b0; r_data = 8'd7;
      tick();
      check("rst_rinc_nonempty", int'(r_inc), 0);
      tick();
      empty = 1'b1;
      r_rstn = 1'b1;
      tick();
      expect_out("post_rst", 0, 0, 0);
      check("post_rst_data", int'(out_data), 0);

      // 2. Fill and first averages, including index wrap.
      pop_one(8'd10); expect_out("fill1", 0, 0, 0);
      pop_one(8'd20); expect_out("fill2", 0, 0, 0);
      pop_one(8'd30); expect_out("fill3", 0, 0, 0);
      pop_one(8'd40); expect_out("fill4", 1, 25, 1);
      pop_one(8'd50); expect_out("run50", 1, 35, 1);
      pop_one(8'd0);  expect_out("run0",  1, 30, 1);

      // 3. Backpressure holds data and blocks pops.
      out_ready = 1'b0; empty = 1'b0; r_data = 8'd62;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp_rinc", int'(r_inc), 0);
         check("bp_data", int'(out_data), 30);
         check("bp_valid", int'(out_valid), 1);
         tick();
      end
      out_ready = 1'b1;
      pop_one(8'd62); expect_out("bp_resume62", 1, 38, 1);
      pop_one(8'd68); expect_out("bp_resume68", 1, 45, 1);
      pop_one(8'd82); expect_out("bp_resume82", 1, 53, 1);
      tick();
      check("drain_valid", int'(out_valid), 0);
      check("drain_data_held", int'(out_data), 53);

      // 4. Empty toggling with full-scale samples.
      do_clr();
      expect_out("clr4", 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         empty = 1'b1; r_data = 8'd255;
         #1;
         check("tog_rinc_empty", int'(r_inc), 0);
         tick();
         if (i >= 4) check("tog_drain_valid", int'(out_valid), 0);
         else        check("tog_idle_full", int'(win_full), 0);
         pop_one(8'd255);
         if (i < 3) expect_out("tog_fill", 0, 0, 0);
         else       expect_out("tog_run", 1, 255, 1);
      end

      // 5. clr in RUN with a pop pending.
      empty = 1'b0; r_data = 8'd99; clr = 1'b1;
      #1;
      check("clr_rinc", int'(r_inc), 0);
      tick();
      clr = 1'b0; empty = 1'b1;
      expect_out("clr_after", 0, 0, 0);
      check("clr_data", int'(out_data), 0);
      pop_one(8'd4); expect_out("clr_fill1", 0, 0, 0);
      pop_one(8'd4); expect_out("clr_fill2", 0, 0, 0);
      pop_one(8'd4); expect_out("clr_fill3", 0, 0, 0);
      pop_one(8'd4); expect_out("clr_fill4", 1, 4, 1);
      tick();
      check("clr_single_out", int'(out_valid), 0);

      // 6. Rounding behaviour.
      do_clr();
      pop_one(8'd1); pop_one(8'd2); pop_one(8'd2); pop_one(8'd2);
`ifdef MAVG_ROUND_EN
      expect_out("rnd_sum7", 1, 2, 1);
`else
      expect_out("rnd_sum7", 1, 1, 1);
`endif
      do_clr();
      pop_one(8'd1); pop_one(8'd1); pop_one(8'd1); pop_one(8'd2);
      expect_out("rnd_sum5", 1, 1, 1);

      // Async reset mid-operation clears outputs immediately.
      r_rstn = 1'b0;
      #1;
      check("arst_valid", int'(out_valid), 0);
      check("arst_data",  int'(out_data),  0);
      check("arst_full",  int'(win_full),  0);
      empty = 1'b0;
      #1;
      check("arst_rinc", int'(r_inc), 0);
      empty = 1'b1;
      tick();
      r_rstn = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_mavg_reader.md
Name: fifo_mavg_reader

Overview:
Read-domain consumer that sits directly downstream of the async FIFO read side. It pops samples whenever the FIFO is non-empty and the output stage can accept data. It keeps a sliding window of the last 2^WIN_LOG2 samples with a running sum, and emits the moving average over a valid/ready interface to the DSP datapath.

Parameters:
D_WIDTH, 8, sample and average width (unsigned).
WIN_LOG2, 2, log2 of window length N (N = 2^WIN_LOG2); legal range 1..6.

Ports:
r_clk  input  1  read domain clock.
r_rstn  input  1  asynchronous active-low reset.
clr  input  1  synchronous window clear, active high.
empty  input  1  FIFO empty flag from the read-pointer logic.
r_data  input  D_WIDTH  FIFO read data at current read address; show-ahead (valid in the same cycle empty=0).
r_inc  output  1  FIFO pop request (combinational).
out_data  output  D_WIDTH  moving-average result.
out_valid  output  1  out_data valid.
out_ready  input  1  downstream accept.
win_full  output  1  window holds N samples (state RUN).

Behaviour:
- Reset (r_rstn=0, async): state=FILL, fill count=0, window buffer entries=0, sum=0, window write index=0, out_data=0, out_valid=0, win_full=0. r_inc=0 while empty=1.
- Handshake:
  - can_take = !out_valid || out_ready.
  - r_inc = !empty && can_take && !clr.
  - A pop occurs on any rising edge where r_inc=1; r_data is captured on that edge.
- Window: circular buffer of N x D_WIDTH entries; the write index wraps from N-1 to 0. On a pop, buf[idx] <= r_data, and idx increments modulo N.
- Sum: width D_WIDTH+WIN_LOG2, unsigned. On a pop, sum_next = sum + r_data - buf[idx], where buf[idx] is the oldest sample, or 0 in FILL because the buffer was cleared. The sum never overflows.
- FSM:
  - FILL: pops update buffer, sum and count; no output is produced. When the Nth pop occurs, go to RUN.
  - RUN: every pop produces an output.
  - win_full=1 exactly while in RUN.
- Output:
  - On a pop in RUN, or on the Nth pop that moves FILL->RUN, the next edge sets out_valid=1 and out_data = sum_next >> WIN_LOG2 (truncation). Latency is 1 cycle from the pop edge to out_valid.
  - out_valid clears on an edge where out_ready=1 and no new pop produces a result.
  - A pop and an accept in the same cycle keep out_valid=1 with the new data (back-to-back throughput of 1 per cycle).
  - While out_valid=1 and out_ready=0: out_data is held stable and r_inc=0.
- empty=1: no pop, and no state/sum/buffer change. out_valid can still drain.
- clr=1 (sync, takes priority over a pop):
  - Next edge: state=FILL, count=0, buffer=0, sum=0, idx=0, out_valid=0, out_data=0.
  - r_inc is forced 0 in that cycle, so no FIFO sample is lost.
- Async reset mid-operation: everything returns to the reset values immediately; no FIFO pop is generated during reset.

Optional Feature:
MAVG_ROUND_EN
- Defined: out_data = (sum_next + 2^(WIN_LOG2-1)) >> WIN_LOG2 (round half up). The intermediate uses D_WIDTH+WIN_LOG2 bits and cannot overflow, since the maximum sum plus N/2 is less than N*2^D_WIDTH.
- Undefined: truncation as in Behaviour. Everything else is identical in both builds.

Test Plan:
1. Reset with empty=1, then release -> all outputs 0, r_inc=0, win_full=0; empty=0 with r_data=7 during reset -> no pop.
2. D_WIDTH=8, WIN_LOG2=2, out_ready=1, FIFO supplies 10,20,30,40 on consecutive cycles -> no out_valid after pops 1-3; win_full=1 and out_valid=1 with out_data=25 one cycle after the 4th pop. Next sample 50 -> out_data=35; next 0 -> 30 (wrap of buffer index checked).
3. Backpressure: in RUN with out_valid=1, drive out_ready=0 for 5 cycles with empty=0 -> r_inc=0, out_data held. Raise out_ready -> pops resume 1/cycle, no sample dropped or duplicated (compare against the reference model).
4. Empty toggling: alternate empty 1/0 every cycle with data 255 x6 -> only empty=0 cycles pop; output 255 once the window fills, sum reaches 1020 without overflow.
5. clr in RUN with a pop pending -> r_inc=0 that cycle; next cycle out_valid=0, win_full=0. Feeding 4,4,4,4 then gives exactly one out_data=4 after the 4th pop.
6. Rounding: window 1,2,2,2 (sum 7) -> out_data=1 without MAVG_ROUND_EN, 2 with it. Window 1,1,1,2 (sum 5) -> 1 in both builds.
